icache_responder: RTL and testbench
===================================

// Module: icache_responder
// PURPOSE
//  Instruction-memory side of the fetch interface: answers the fetch stage's instruction
//  address with the 32-bit instruction word in the same cycle on a hit.
//  Direct-mapped, read-only instruction cache.
//  On a miss: raises a stall to fetch, then refills the line from backing memory over a
//  req/ack handshake, one word at a time.
//  Sits between the IF stage and the unified memory model.
// PARAMETERS
//  LINES           16   number of cache lines; power of 2, >=2
//  WORDS_PER_LINE  4    32-bit words per line; power of 2, >=2
// PORTS
//  CLK               in   1   clock; all state updates on posedge
//  RESET             in   1   asynchronous, active-low reset
//  Instr_address_fIF in   32  fetch address; bits [1:0] ignored
//  Instr1_2IF        out  32  instruction word for Instr_address_fIF; 0 when not a hit
//  STALL_2IF         out  1   high while the requested word is not available
//  Inv               in   1   one-cycle pulse: invalidate entire cache
//  Mem_req           out  1   backing-memory read request; held until acked
//  Mem_addr          out  32  word-aligned backing-memory read address
//  Mem_ack           in   1   read data valid on Mem_data this cycle
//  Mem_data          in   32  backing-memory read data
// BEHAVIOUR
//  - Address split: offset = [OB+1:2], OB = log2(WORDS_PER_LINE).
//    Index = next log2(LINES) bits; tag = remaining upper bits.
//  - Arrays: valid[LINES], tag[LINES], data[LINES*WORDS_PER_LINE].
//    Lookup is combinational from Instr_address_fIF; no pipeline register.
//  - hit = state==IDLE && valid[idx] && tag[idx]==addr tag.
//    Instr1_2IF = hit ? word : 0.  STALL_2IF = RESET && !hit.
//  - While RESET low: valid all 0, state IDLE, Mem_req=0, Mem_addr=0, STALL_2IF=0, Instr1_2IF=0.
//  - FSM IDLE:
//    - On a miss, latch the line base (addr with offset bits and [1:0] zeroed) and tag.
//    - Set cnt=0, Mem_req=1, Mem_addr=base; go to FILL.
//  - FSM FILL:
//    - On Mem_ack: write Mem_data to data[idx][cnt].
//    - If cnt != WORDS_PER_LINE-1: cnt+1, Mem_addr+4, Mem_req stays 1.
//    - Else: Mem_req=0; set tag, and valid unless killed; go to IDLE.
//    - Mem_req and Mem_addr are stable while Mem_ack is low.
//    - Mem_ack is ignored when Mem_req=0.
//  - Latency:
//    - Hit: 0 cycles.
//    - Miss, N-cycle acks: stall lasts until the cycle after the last ack, then hit on re-lookup.
//  - The refill uses the latched base; address changes during FILL do not redirect it.
//    After FILL, the current address is looked up afresh and may miss again.
//  - Inv in IDLE: all valid cleared next edge.
//    Inv during FILL: all valid cleared, kill flag set; the fill completes, line is left invalid.
//    kill is cleared on entering IDLE.
//  - Conflict eviction: a refill simply overwrites the indexed line; no writeback (read-only).
//  - Reset mid-FILL: aborts immediately.
//    A partially written line stays invalid; any Mem_ack arriving afterwards is ignored.
// CONFIGURATION
//  ICACHE_STATS_EN defined:
//    - Adds outputs Hit_count[31:0] and Miss_count[31:0], both reset to 0, wrap on overflow.
//    - Hit_count +1 on every cycle with hit=1.
//    - Miss_count +1 on every IDLE->FILL transition.
//  ICACHE_STATS_EN undefined: counters and ports are absent; behaviour otherwise identical.
// TESTING (LINES=16, WORDS_PER_LINE=4; memory returns data = addr ^ 32'hA5A5A5A5)
//  1 Cold miss: reset, then addr 0xBFC00000, Mem_ack immediate.
//    -> STALL_2IF=1; Mem_addr 0xBFC00000/04/08/0C.
//    -> Next cycle STALL_2IF=0, Instr1_2IF=0x1A65A5A5.
//  2 Same line: then addr 0xBFC0000C -> same-cycle hit, Instr1_2IF=0x1A65A5A9, Mem_req stays 0.
//  3 Conflict: addr 0xBFC00100 (index 0, new tag) -> refill at 0xBFC00100..10C.
//    -> Then 0xBFC00000 misses again.
//  4 Slow memory: Mem_ack low 5 cycles per word.
//    -> Mem_req and Mem_addr stable throughout; STALL_2IF high for the full 24 cycles.
//  5 Reset mid-fill: assert RESET low after 2 acks -> Mem_req=0 immediately.
//    -> After release, 0xBFC00000 misses; a stray Mem_ack writes nothing.
//  6 Inv during FILL -> fill completes, then the same address misses again.
//    With ICACHE_STATS_EN: Miss_count=2, Hit_count=0.

Source files
------------

// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache answering the fetch stage in the same cycle on a hit.
// Optional hit/miss counters are enabled with `define ICACHE_STATS_EN.
module icache_responder #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr_address_fIF,
  output logic [31:0] Instr1_2IF,
  output logic        STALL_2IF,
  input  logic        Inv,
  output logic        Mem_req,
  output logic [31:0] Mem_addr,
  input  logic        Mem_ack,
  input  logic [31:0] Mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] Hit_count,
  output logic [31:0] Miss_count
`endif
);

  localparam int OB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(LINES);
  localparam int LW = 30 - OB;
  localparam int TW = LW - IB;

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [LINES-1:0]  r_valid;
  logic [TW-1:0]     r_tag  [LINES];
  logic [31:0]       r_data [LINES*WORDS_PER_LINE];
  logic [LW-1:0]     r_line;
  logic [OB-1:0]     r_cnt;
  logic              r_kill;
  logic [31:0]       r_mem_addr;

  logic [OB-1:0]     w_off;
  logic [IB-1:0]     w_idx;
  logic [TW-1:0]     w_tag;
  logic [IB-1:0]     w_fill_idx;
  logic [TW-1:0]     w_fill_tag;
  logic              w_hit;
  logic              w_miss;
  logic              w_fill_ack;
  logic              w_last;
  logic              w_unused_bits;

  assign w_off         = Instr_address_fIF[OB+1:2];
  assign w_idx         = Instr_address_fIF[OB+IB+1:OB+2];
  assign w_tag         = Instr_address_fIF[31:OB+IB+2];
  assign w_unused_bits = ^Instr_address_fIF[1:0];
  assign w_fill_idx    = r_line[IB-1:0];
  assign w_fill_tag    = r_line[LW-1:IB];

  assign w_hit      = (r_state == S_IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss     = (r_state == S_IDLE) && !w_hit;
  assign w_fill_ack = (r_state == S_FILL) && Mem_ack;
  assign w_last     = (r_cnt == OB'(WORDS_PER_LINE - 1));

  assign Instr1_2IF = w_hit ? r_data[{w_idx, w_off}] : 32'd0;
  assign STALL_2IF  = RESET && !w_hit;
  assign Mem_req    = (r_state == S_FILL);
  assign Mem_addr   = r_mem_addr;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_miss) w_state_next = S_FILL;
      S_FILL:  if (Mem_ack && w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Inv wins over a completing fill; kill keeps a line invalidated mid-fill from going valid.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid    <= '0;
      r_line     <= '0;
      r_cnt      <= '0;
      r_kill     <= 1'b0;
      r_mem_addr <= 32'd0;
    end else begin
      if (r_state == S_IDLE) begin
        r_kill <= 1'b0;
        if (w_miss) begin
          r_line     <= Instr_address_fIF[31:OB+2];
          r_cnt      <= '0;
          r_mem_addr <= {Instr_address_fIF[31:OB+2], {(OB+2){1'b0}}};
        end
      end else if (Mem_ack && !w_last) begin
        r_cnt      <= r_cnt + 1'b1;
        r_mem_addr <= r_mem_addr + 32'd4;
      end
      if (Inv) begin
        r_valid <= '0;
        if (r_state == S_FILL) r_kill <= 1'b1;
      end else if (w_fill_ack && w_last && !r_kill) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_fill_ack) r_data[{w_fill_idx, r_cnt}] <= Mem_data;
    if (w_fill_ack && w_last) r_tag[w_fill_idx] <= w_fill_tag;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_hit_count  <= 32'd0;
      r_miss_count <= 32'd0;
    end else begin
      if (w_hit)  r_hit_count  <= r_hit_count + 32'd1;
      if (w_miss) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign Hit_count  = r_hit_count;
  assign Miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios plus a randomized run
// against a line-level cache model; memory returns addr ^ 32'hA5A5A5A5.
module tb_icache_responder;

  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr_address_fIF;
  logic [31:0] Instr1_2IF;
  logic        STALL_2IF;
  logic        Inv;
  logic        Mem_req;
  logic [31:0] Mem_addr;
  logic        Mem_ack;
  logic [31:0] Mem_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] Hit_count;
  logic [31:0] Miss_count;
`endif

  int          nChecks  = 0;
  int          nFails   = 0;
  int          ackGap   = 0;
  int          waitCnt  = 0;
  bit          strayAck = 1'b0;
  bit          mValid [16];
  logic [23:0] mTag   [16];

  icache_responder #(.LINES(16), .WORDS_PER_LINE(4)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .Instr_address_fIF (Instr_address_fIF),
    .Instr1_2IF        (Instr1_2IF),
    .STALL_2IF         (STALL_2IF),
    .Inv               (Inv),
    .Mem_req           (Mem_req),
    .Mem_addr          (Mem_addr),
    .Mem_ack           (Mem_ack),
    .Mem_data          (Mem_data)
`ifdef ICACHE_STATS_EN
    ,
    .Hit_count         (Hit_count),
    .Miss_count        (Miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one clock and play the memory side for the new cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (Mem_req) begin
      if (waitCnt >= ackGap) begin
        Mem_ack  = 1'b1;
        Mem_data = Mem_addr ^ KEY;
        waitCnt  = 0;
      end else begin
        Mem_ack  = 1'b0;
        Mem_data = $urandom;
        waitCnt++;
      end
    end else begin
      Mem_ack  = strayAck;
      Mem_data = $urandom;
      waitCnt  = 0;
    end
  endtask

  task automatic applyReset();
    RESET             = 1'b0;
    Inv               = 1'b0;
    Mem_ack           = 1'b0;
    Mem_data          = 32'd0;
    strayAck          = 1'b0;
    ackGap            = 0;
    waitCnt           = 0;
    Instr_address_fIF = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
  endtask

  // Follows a refill until Mem_req drops; returns observations, ends at the negedge of the re-lookup cycle.
  task automatic runFill(input logic [31:0] base, input int startWords, output int words,
                         output int cycles, output bit addrOk, output bit stallOk, output bit timedOut);
    words    = startWords;
    cycles   = 0;
    addrOk   = 1'b1;
    stallOk  = 1'b1;
    timedOut = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      @(negedge CLK);
      if (!Mem_req) begin
        timedOut = 1'b0;
        break;
      end
      if (Mem_addr !== base + 32'(4 * words)) addrOk = 1'b0;
      if (STALL_2IF !== 1'b1) stallOk = 1'b0;
      if (Mem_ack) words++;
      cycles++;
    end
  endtask

  task automatic test_reset();
    RESET             = 1'b0;
    Inv               = 1'b0;
    Mem_ack           = 1'b1;
    Mem_data          = 32'hDEADBEEF;
    Instr_address_fIF = 32'hBFC00000;
    @(negedge CLK);
    nChecks++;
    if (Mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL reset_mem_req: got %b expected 0", Mem_req); end
    nChecks++;
    if (Mem_addr !== 32'd0) begin nFails++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", Mem_addr); end
    nChecks++;
    if (STALL_2IF !== 1'b0) begin nFails++; $display("[TB] FAIL reset_stall: got %b expected 0", STALL_2IF); end
    nChecks++;
    if (Instr1_2IF !== 32'd0) begin nFails++; $display("[TB] FAIL reset_instr: got %h expected 0", Instr1_2IF); end
    @(posedge CLK);
    #1;
    RESET   = 1'b1;
    Mem_ack = 1'b0;
    @(negedge CLK);
    nChecks++;
    if (STALL_2IF !== 1'b1) begin nFails++; $display("[TB] FAIL post_reset_miss_stall: got %b expected 1", STALL_2IF); end
    nChecks++;
    if (Mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL post_reset_req_idle: got %b expected 0", Mem_req); end
    tick();
    @(negedge CLK);
    nChecks++;
    if (Mem_req !== 1'b1 || Mem_addr !== 32'hBFC00000) begin
      nFails++;
      $display("[TB] FAIL first_request: got req=%b addr=%h expected req=1 addr=bfc00000", Mem_req, Mem_addr);
    end
  endtask

  task automatic test_cold_miss();
    int words, cycles;
    bit aOk, sOk, to;
    int offs [4] = '{3, 1, 2, 0};
    logic [31:0] a;
    applyReset();
    Instr_address_fIF = 32'hBFC00000;
    @(negedge CLK);
    nChecks++;
    if (STALL_2IF !== 1'b1 || Instr1_2IF !== 32'd0) begin
      nFails++;
      $display("[TB] FAIL cold_miss_lookup: got stall=%b instr=%h expected stall=1 instr=0", STALL_2IF, Instr1_2IF);
    end
    runFill(32'hBFC00000, 0, words, cycles, aOk, sOk, to);
    nChecks++;
    if (to || words != 4) begin nFails++; $display("[TB] FAIL cold_fill_words: got %0d timeout=%b expected 4", words, to); end
    nChecks++;
    if (!aOk) begin nFails++; $display("[TB] FAIL cold_mem_addr_sequence: got out-of-order address expected bfc00000..0c"); end
    nChecks++;
    if (!sOk) begin nFails++; $display("[TB] FAIL cold_stall_during_fill: got stall low expected high"); end
    nChecks++;
    if (cycles != 4) begin nFails++; $display("[TB] FAIL cold_fill_cycles: got %0d expected 4", cycles); end
    nChecks++;
    if (STALL_2IF !== 1'b0 || Instr1_2IF !== 32'h1A65A5A5) begin
      nFails++;
      $display("[TB] FAIL cold_relookup: got stall=%b instr=%h expected stall=0 instr=1a65a5a5", STALL_2IF, Instr1_2IF);
    end
    tick();
    Instr_address_fIF = 32'hBFC0000C;
    @(negedge CLK);
    nChecks++;
    if (Instr1_2IF !== 32'h1A65A5A9 || STALL_2IF !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL same_line_hit: got stall=%b instr=%h expected stall=0 instr=1a65a5a9", STALL_2IF, Instr1_2IF);
    end
    foreach (offs[i]) begin
      tick();
      a = 32'hBFC00000 + 32'(4 * offs[i]) + 32'($urandom_range(0, 3));
      Instr_address_fIF = a;
      @(negedge CLK);
      nChecks++;
      if (Instr1_2IF !== ({a[31:2], 2'b00} ^ KEY) || Mem_req !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL line_word_hit: addr=%h got instr=%h req=%b expected instr=%h req=0",
                 a, Instr1_2IF, Mem_req, {a[31:2], 2'b00} ^ KEY);
      end
    end
  endtask

  task automatic test_conflict();
    int words, cycles;
    bit aOk, sOk, to;
    applyReset();
    Instr_address_fIF = 32'hBFC00000;
    @(negedge CLK);
    runFill(32'hBFC00000, 0, words, cycles, aOk, sOk, to);
    tick();
    Instr_address_fIF = 32'hBFC00100;
    @(negedge CLK);
    nChecks++;
    if (STALL_2IF !== 1'b1) begin nFails++; $display("[TB] FAIL conflict_miss: got stall=%b expected 1", STALL_2IF); end
    runFill(32'hBFC00100, 0, words, cycles, aOk, sOk, to);
    nChecks++;
    if (to || words != 4 || !aOk) begin
      nFails++;
      $display("[TB] FAIL conflict_refill: got words=%0d addrOk=%b expected words=4 addrOk=1", words, aOk);
    end
    nChecks++;
    if (Instr1_2IF !== (32'hBFC00100 ^ KEY)) begin
      nFails++;
      $display("[TB] FAIL conflict_new_data: got %h expected %h", Instr1_2IF, 32'hBFC00100 ^ KEY);
    end
    tick();
    Instr_address_fIF = 32'hBFC00000;
    @(negedge CLK);
    nChecks++;
    if (STALL_2IF !== 1'b1 || Instr1_2IF !== 32'd0) begin
      nFails++;
      $display("[TB] FAIL evicted_line_miss: got stall=%b instr=%h expected stall=1 instr=0", STALL_2IF, Instr1_2IF);
    end
    runFill(32'hBFC00000, 0, words, cycles, aOk, sOk, to);
  endtask

  task automatic test_slow_memory();
    int words, cycles;
    bit aOk, sOk, to;
    applyReset();
    ackGap = 5;
    Instr_address_fIF = 32'h00001234;
    @(negedge CLK);
    runFill(32'h00001230, 0, words, cycles, aOk, sOk, to);
    nChecks++;
    if (to || words != 4) begin nFails++; $display("[TB] FAIL slow_words: got %0d expected 4", words); end
    nChecks++;
    if (!aOk) begin nFails++; $display("[TB] FAIL slow_addr_stable: got moving address expected stable until ack"); end
    nChecks++;
    if (!sOk || cycles != 24) begin
      nFails++;
      $display("[TB] FAIL slow_stall_cycles: got %0d stallOk=%b expected 24 stallOk=1", cycles, sOk);
    end
    nChecks++;
    if (Instr1_2IF !== (32'h00001234 ^ KEY) || STALL_2IF !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL slow_hit: got %h expected %h", Instr1_2IF, 32'h00001234 ^ KEY);
    end
    ackGap = 0;
  endtask

  task automatic test_reset_mid_fill();
    int words, cycles, seen, guard;
    bit aOk, sOk, to;
    applyReset();
    Instr_address_fIF = 32'hBFC00000;
    @(negedge CLK);
    seen  = 0;
    guard = 0;
    while (seen < 2 && guard < 20) begin
      tick();
      if (Mem_req && Mem_ack) seen++;
      guard++;
    end
    tick();
    nChecks++;
    if (Mem_req !== 1'b1) begin nFails++; $display("[TB] FAIL midfill_req_before_reset: got %b expected 1", Mem_req); end
    RESET = 1'b0;
    #1;
    nChecks++;
    if (Mem_req !== 1'b0 || STALL_2IF !== 1'b0 || Instr1_2IF !== 32'd0 || Mem_addr !== 32'd0) begin
      nFails++;
      $display("[TB] FAIL midfill_abort: got req=%b stall=%b instr=%h addr=%h expected all 0",
               Mem_req, STALL_2IF, Instr1_2IF, Mem_addr);
    end
    strayAck = 1'b1;
    tick();
    tick();
    RESET = 1'b1;
    for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
    @(negedge CLK);
    nChecks++;
    if (STALL_2IF !== 1'b1 || Mem_req !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL after_abort_miss: got stall=%b req=%b expected stall=1 req=0", STALL_2IF, Mem_req);
    end
    strayAck = 1'b0;
    runFill(32'hBFC00000, 0, words, cycles, aOk, sOk, to);
    nChecks++;
    if (to || words != 4 || !aOk || Instr1_2IF !== 32'h1A65A5A5) begin
      nFails++;
      $display("[TB] FAIL after_abort_refill: got words=%0d instr=%h expected 4 1a65a5a5", words, Instr1_2IF);
    end
  endtask

  task automatic test_inv();
    int words, cycles;
    bit aOk, sOk, to;
    logic [31:0] a = 32'h00400044;
    applyReset();
    ackGap = 1;
    Instr_address_fIF = a;
    @(negedge CLK);
    words = 0;
    tick();
    if (Mem_ack) words++;
    Inv = 1'b1;
    tick();
    Inv = 1'b0;
    if (Mem_ack) words++;
    runFill(32'h00400040, words, words, cycles, aOk, sOk, to);
    nChecks++;
    if (to || words != 4 || !aOk) begin
      nFails++;
      $display("[TB] FAIL inv_fill_completes: got words=%0d addrOk=%b expected 4 1", words, aOk);
    end
    nChecks++;
    if (STALL_2IF !== 1'b1 || Instr1_2IF !== 32'd0) begin
      nFails++;
      $display("[TB] FAIL inv_killed_line_miss: got stall=%b instr=%h expected stall=1 instr=0", STALL_2IF, Instr1_2IF);
    end
    runFill(32'h00400040, 0, words, cycles, aOk, sOk, to);
    nChecks++;
    if (STALL_2IF !== 1'b0 || Instr1_2IF !== ({a[31:2], 2'b00} ^ KEY)) begin
      nFails++;
      $display("[TB] FAIL inv_refill_hit: got stall=%b instr=%h expected 0 %h", STALL_2IF, Instr1_2IF, a ^ KEY);
    end
`ifdef ICACHE_STATS_EN
    nChecks++;
    if (Miss_count !== 32'd2 || Hit_count !== 32'd0) begin
      nFails++;
      $display("[TB] FAIL inv_stats: got miss=%0d hit=%0d expected miss=2 hit=0", Miss_count, Hit_count);
    end
`endif
    Inv = 1'b1;
    tick();
    Inv = 1'b0;
    @(negedge CLK);
    nChecks++;
    if (STALL_2IF !== 1'b1) begin nFails++; $display("[TB] FAIL inv_idle_clears: got stall=%b expected 1", STALL_2IF); end
    runFill(32'h00400040, 0, words, cycles, aOk, sOk, to);
    ackGap = 0;
  endtask

  task automatic test_random();
    logic [23:0] tags [3] = '{24'hBFC000, 24'h000010, 24'h7FFFFF};
    logic [31:0] a, expData;
    logic [3:0]  idx;
    bit          expHit, aOk, sOk, to;
    int          words, cycles;
    int          hits = 0;
    int          misses = 0;
    applyReset();
    for (int t = 0; t < 150; t++) begin
      a = {tags[$urandom_range(0, 2)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      Instr_address_fIF = a;
      idx     = a[7:4];
      expData = {a[31:2], 2'b00} ^ KEY;
      expHit  = mValid[idx] && (mTag[idx] == a[31:8]);
      @(negedge CLK);
      if (expHit) begin
        hits++;
        nChecks++;
        if (STALL_2IF !== 1'b0 || Instr1_2IF !== expData) begin
          nFails++;
          $display("[TB] FAIL rand_hit: addr=%h got stall=%b instr=%h expected stall=0 instr=%h", a, STALL_2IF, Instr1_2IF, expData);
        end
        if ($urandom_range(0, 19) == 0) begin
          Inv = 1'b1;
          tick();
          Inv = 1'b0;
          for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
        end else begin
          tick();
        end
      end else begin
        misses++;
        nChecks++;
        if (STALL_2IF !== 1'b1 || Instr1_2IF !== 32'd0) begin
          nFails++;
          $display("[TB] FAIL rand_miss: addr=%h got stall=%b instr=%h expected stall=1 instr=0", a, STALL_2IF, Instr1_2IF);
        end
        ackGap = $urandom_range(0, 2);
        runFill({a[31:4], 4'b0000}, 0, words, cycles, aOk, sOk, to);
        nChecks++;
        if (to || words != 4 || !aOk || !sOk) begin
          nFails++;
          $display("[TB] FAIL rand_fill: addr=%h got words=%0d addrOk=%b stallOk=%b expected 4 1 1", a, words, aOk, sOk);
        end
        mValid[idx] = 1'b1;
        mTag[idx]   = a[31:8];
        hits++;
        nChecks++;
        if (STALL_2IF !== 1'b0 || Instr1_2IF !== expData) begin
          nFails++;
          $display("[TB] FAIL rand_relookup: addr=%h got stall=%b instr=%h expected stall=0 instr=%h", a, STALL_2IF, Instr1_2IF, expData);
        end
        tick();
      end
    end
`ifdef ICACHE_STATS_EN
    nChecks++;
    if (Hit_count !== 32'(hits) || Miss_count !== 32'(misses)) begin
      nFails++;
      $display("[TB] FAIL rand_stats: got hit=%0d miss=%0d expected hit=%0d miss=%0d", Hit_count, Miss_count, hits, misses);
    end
`endif
    ackGap = 0;
  endtask

  initial begin
    $display("[TB] icache_responder bench starting");
    test_reset();
    test_cold_miss();
    test_conflict();
    test_slow_memory();
    test_reset_mid_fill();
    test_inv();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
